// File: rtl/vx_commit_wb_arbiter.sv
// Per-slot commit arbiter: round-robin with multi-packet lock over the execution-unit result
// streams, a registered writeback channel, and retire counters. Optional: VX_WB_THREAD_STATS_EN.
module vx_commit_wb_arbiter #(
    parameter int NUM_UNITS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 6,
    parameter int XLEN        = 32,
    parameter int UUID_WIDTH  = 1,
    parameter int CTR_BITS    = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_UNITS-1:0]                  commit_valid,
    output logic [NUM_UNITS-1:0]                  commit_ready,
    input  logic [NUM_UNITS*UUID_WIDTH-1:0]       commit_uuid,
    input  logic [NUM_UNITS*NW_BITS-1:0]          commit_wid,
    input  logic [NUM_UNITS*NUM_THREADS-1:0]      commit_tmask,
    input  logic [NUM_UNITS*XLEN-1:0]             commit_pc,
    input  logic [NUM_UNITS-1:0]                  commit_wb,
    input  logic [NUM_UNITS*NR_BITS-1:0]          commit_rd,
    input  logic [NUM_UNITS*NUM_THREADS*XLEN-1:0] commit_data,
    input  logic [NUM_UNITS-1:0]                  commit_sop,
    input  logic [NUM_UNITS-1:0]                  commit_eop,
    output logic                                  wb_valid,
    output logic [UUID_WIDTH-1:0]                 wb_uuid,
    output logic [NW_BITS-1:0]                    wb_wid,
    output logic [NUM_THREADS-1:0]                wb_tmask,
    output logic [XLEN-1:0]                       wb_pc,
    output logic [NR_BITS-1:0]                    wb_rd,
    output logic [NUM_THREADS*XLEN-1:0]           wb_data,
    output logic                                  wb_eop,
    output logic [CTR_BITS-1:0]                   retire_count,
    output logic [CTR_BITS-1:0]                   thread_count
);

    localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int DW    = NUM_THREADS * XLEN;

    logic [PTR_W-1:0] rr_ptr, rr_ptr_n;
    logic             locked, locked_n;
    logic [PTR_W-1:0] lock_idx, lock_idx_n;

    logic [NUM_UNITS-1:0] grant;
    logic [PTR_W-1:0]     win_idx;
    logic                 found;
    int                   idx;
    logic                 fire;

    logic [UUID_WIDTH-1:0]  sel_uuid;
    logic [NW_BITS-1:0]     sel_wid;
    logic [NUM_THREADS-1:0] sel_tmask;
    logic [XLEN-1:0]        sel_pc;
    logic [NR_BITS-1:0]     sel_rd;
    logic [DW-1:0]          sel_data;
    logic                   sel_wb;
    logic                   sel_sop;
    logic                   sel_eop;

    // Winner search; a held lock pins the grant to the locked unit regardless of its valid.
    always_comb begin
        grant   = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        if (!reset) begin
            if (locked) begin
                grant[lock_idx] = 1'b1;
                win_idx         = lock_idx;
            end else begin
                for (int i = 0; i < NUM_UNITS; i++) begin
                    idx = int'(rr_ptr) + i;
                    if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
                    if (!found && commit_valid[idx]) begin
                        found      = 1'b1;
                        grant[idx] = 1'b1;
                        win_idx    = PTR_W'(idx);
                    end
                end
            end
        end
    end

    assign commit_ready = grant;
    assign fire         = |(grant & commit_valid);

    // AND-OR mux of the granted unit's fields (grant is one-hot or zero).
    always_comb begin
        sel_uuid  = '0;
        sel_wid   = '0;
        sel_tmask = '0;
        sel_pc    = '0;
        sel_rd    = '0;
        sel_data  = '0;
        sel_wb    = 1'b0;
        sel_sop   = 1'b0;
        sel_eop   = 1'b0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            sel_uuid  = sel_uuid  | ({UUID_WIDTH{grant[k]}} & commit_uuid[k*UUID_WIDTH +: UUID_WIDTH]);
            sel_wid   = sel_wid   | ({NW_BITS{grant[k]}} & commit_wid[k*NW_BITS +: NW_BITS]);
            sel_tmask = sel_tmask | ({NUM_THREADS{grant[k]}} &
                                     commit_tmask[k*NUM_THREADS +: NUM_THREADS]);
            sel_pc    = sel_pc    | ({XLEN{grant[k]}} & commit_pc[k*XLEN +: XLEN]);
            sel_rd    = sel_rd    | ({NR_BITS{grant[k]}} & commit_rd[k*NR_BITS +: NR_BITS]);
            sel_data  = sel_data  | ({DW{grant[k]}} & commit_data[k*DW +: DW]);
            sel_wb    = sel_wb    | (grant[k] & commit_wb[k]);
            sel_sop   = sel_sop   | (grant[k] & commit_sop[k]);
            sel_eop   = sel_eop   | (grant[k] & commit_eop[k]);
        end
    end

    always_comb begin
        rr_ptr_n   = rr_ptr;
        locked_n   = locked;
        lock_idx_n = lock_idx;
        if (fire) begin
            if (sel_eop) begin
                locked_n = 1'b0;
                rr_ptr_n = (win_idx == PTR_W'(NUM_UNITS - 1)) ? '0 : win_idx + 1'b1;
            end else if (sel_sop) begin
                locked_n   = 1'b1;
                lock_idx_n = win_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr       <= '0;
            locked       <= 1'b0;
            lock_idx     <= '0;
            wb_valid     <= 1'b0;
            wb_uuid      <= '0;
            wb_wid       <= '0;
            wb_tmask     <= '0;
            wb_pc        <= '0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_eop       <= 1'b0;
            retire_count <= '0;
        end else begin
            rr_ptr   <= rr_ptr_n;
            locked   <= locked_n;
            lock_idx <= lock_idx_n;
            wb_valid <= fire && sel_wb;
            if (fire && sel_wb) begin
                wb_uuid  <= sel_uuid;
                wb_wid   <= sel_wid;
                wb_tmask <= sel_tmask;
                wb_pc    <= sel_pc;
                wb_rd    <= sel_rd;
                wb_data  <= sel_data;
                wb_eop   <= sel_eop;
            end
            if (fire && sel_eop) retire_count <= retire_count + 1'b1;
        end
    end

`ifdef VX_WB_THREAD_STATS_EN
    logic [CTR_BITS-1:0] thread_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            thread_cnt_q <= '0;
        end else if (fire && sel_eop) begin
            thread_cnt_q <= thread_cnt_q + CTR_BITS'($countones(sel_tmask));
        end
    end

    assign thread_count = thread_cnt_q;
`else
    assign thread_count = '0;
`endif

endmodule

// File: tb/tb_vx_commit_wb_arbiter.sv
// Directed bench for vx_commit_wb_arbiter: vector table for round-robin order plus hand-written
// lock, reset-while-locked and counter-wrap sequences. Counters are built 4 bits wide.
module tb_vx_commit_wb_arbiter;

    localparam int NU  = 4;
    localparam int NT  = 4;
    localparam int NWB = 2;
    localparam int NRB = 6;
    localparam int XL  = 32;
    localparam int UW  = 1;
    localparam int CTR = 4;

    logic                    clk;
    logic                    reset;
    logic [NU-1:0]           commit_valid;
    logic [NU-1:0]           commit_ready;
    logic [NU*UW-1:0]        commit_uuid;
    logic [NU*NWB-1:0]       commit_wid;
    logic [NU*NT-1:0]        commit_tmask;
    logic [NU*XL-1:0]        commit_pc;
    logic [NU-1:0]           commit_wb;
    logic [NU*NRB-1:0]       commit_rd;
    logic [NU*NT*XL-1:0]     commit_data;
    logic [NU-1:0]           commit_sop;
    logic [NU-1:0]           commit_eop;
    logic                    wb_valid;
    logic [UW-1:0]           wb_uuid;
    logic [NWB-1:0]          wb_wid;
    logic [NT-1:0]           wb_tmask;
    logic [XL-1:0]           wb_pc;
    logic [NRB-1:0]          wb_rd;
    logic [NT*XL-1:0]        wb_data;
    logic                    wb_eop;
    logic [CTR-1:0]          retire_count;
    logic [CTR-1:0]          thread_count;

    vx_commit_wb_arbiter #(
        .NUM_UNITS(NU), .NUM_THREADS(NT), .NW_BITS(NWB), .NR_BITS(NRB),
        .XLEN(XL), .UUID_WIDTH(UW), .CTR_BITS(CTR)
    ) dut (
        .clk(clk), .reset(reset),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_uuid(commit_uuid), .commit_wid(commit_wid), .commit_tmask(commit_tmask),
        .commit_pc(commit_pc), .commit_wb(commit_wb), .commit_rd(commit_rd),
        .commit_data(commit_data), .commit_sop(commit_sop), .commit_eop(commit_eop),
        .wb_valid(wb_valid), .wb_uuid(wb_uuid), .wb_wid(wb_wid), .wb_tmask(wb_tmask),
        .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data), .wb_eop(wb_eop),
        .retire_count(retire_count), .thread_count(thread_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [CTR-1:0] exp_ret;
    logic [CTR-1:0] exp_thr;
    logic [NRB-1:0] last_rd;

    typedef struct {
        logic [NU-1:0] valid;
        logic [NU-1:0] wb;
        logic [NU-1:0] exp_ready;
        logic          exp_wbv;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NT-1:0] tm(input int tag, input int k);
        return NT'(tag + k + 4);
    endfunction

    task automatic set_fields(input int tag);
        for (int k = 0; k < NU; k++) begin
            commit_uuid[k]                = k[0];
            commit_wid[k*NWB +: NWB]      = NWB'(k);
            commit_tmask[k*NT +: NT]      = tm(tag, k);
            commit_pc[k*XL +: XL]         = 32'h1000 + 32'(k * 4);
            commit_rd[k*NRB +: NRB]       = NRB'(tag * 4 + k);
            for (int t = 0; t < NT; t++)
                commit_data[(k*NT+t)*XL +: XL] = 32'(tag * 256 + k * 16 + t);
        end
    endtask

    task automatic chk_ctrs(input string name);
        chk({name, "_retire"}, 64'(retire_count), 64'(exp_ret));
`ifdef VX_WB_THREAD_STATS_EN
        chk({name, "_threads"}, 64'(thread_count), 64'(exp_thr));
`else
        chk({name, "_threads"}, 64'(thread_count), 64'd0);
`endif
    endtask

    // One cycle: drive, check ready combinationally, then check the registered outputs.
    task automatic cyc(input logic [NU-1:0] valid, input logic [NU-1:0] wb,
                       input logic [NU-1:0] sop, input logic [NU-1:0] eop,
                       input logic [NU-1:0] exp_ready, input logic exp_wbv,
                       input int tag, input string name);
        int win;
        logic [NT-1:0] wtm;
        @(negedge clk);
        commit_valid = valid;
        commit_wb    = wb;
        commit_sop   = sop;
        commit_eop   = eop;
        set_fields(tag);
        #1;
        chk({name, "_ready"}, 64'(commit_ready), 64'(exp_ready));
        win = -1;
        for (int k = 0; k < NU; k++) if (exp_ready[k] && valid[k]) win = k;
        @(posedge clk);
        #1;
        chk({name, "_wbv"}, 64'(wb_valid), 64'(exp_wbv));
        if (win >= 0 && eop[win]) begin
            wtm     = tm(tag, win);
            exp_ret = exp_ret + 1'b1;
            exp_thr = exp_thr + CTR'($countones(wtm));
        end
        if (exp_wbv && win >= 0) begin
            last_rd = NRB'(tag * 4 + win);
            chk({name, "_rd"}, 64'(wb_rd), 64'(last_rd));
            chk({name, "_tmask"}, 64'(wb_tmask), 64'(tm(tag, win)));
            chk({name, "_data"}, 64'(wb_data[XL-1:0]), 64'(tag * 256 + win * 16));
            chk({name, "_pc"}, 64'(wb_pc), 64'(32'h1000 + win * 4));
            chk({name, "_eop"}, 64'(wb_eop), 64'(eop[win]));
        end else begin
            chk({name, "_rd_hold"}, 64'(wb_rd), 64'(last_rd));
        end
        chk_ctrs(name);
    endtask

    task automatic do_reset(input logic [NU-1:0] valid);
        @(negedge clk);
        reset        = 1'b1;
        commit_valid = valid;
        commit_wb    = valid;
        commit_sop   = valid;
        commit_eop   = valid;
        #1;
        chk("rst_ready", 64'(commit_ready), 64'd0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_ret = '0;
        exp_thr = '0;
        last_rd = '0;
        chk("rst_wbv", 64'(wb_valid), 64'd0);
        chk("rst_rd", 64'(wb_rd), 64'd0);
        chk_ctrs("rst");
    endtask

    initial begin
        vecs[0]  = '{valid: 4'b1111, wb: 4'b1111, exp_ready: 4'b0010, exp_wbv: 1'b1};
        vecs[1]  = '{valid: 4'b1111, wb: 4'b1111, exp_ready: 4'b0100, exp_wbv: 1'b1};
        vecs[2]  = '{valid: 4'b1111, wb: 4'b1111, exp_ready: 4'b1000, exp_wbv: 1'b1};
        vecs[3]  = '{valid: 4'b1111, wb: 4'b1111, exp_ready: 4'b0001, exp_wbv: 1'b1};
        vecs[4]  = '{valid: 4'b0000, wb: 4'b1111, exp_ready: 4'b0000, exp_wbv: 1'b0};
        vecs[5]  = '{valid: 4'b1000, wb: 4'b0000, exp_ready: 4'b1000, exp_wbv: 1'b0};
        vecs[6]  = '{valid: 4'b0110, wb: 4'b1111, exp_ready: 4'b0010, exp_wbv: 1'b1};
        vecs[7]  = '{valid: 4'b0101, wb: 4'b1111, exp_ready: 4'b0100, exp_wbv: 1'b1};
        vecs[8]  = '{valid: 4'b0001, wb: 4'b0001, exp_ready: 4'b0001, exp_wbv: 1'b1};
        vecs[9]  = '{valid: 4'b1001, wb: 4'b1001, exp_ready: 4'b1000, exp_wbv: 1'b1};
        vecs[10] = '{valid: 4'b0011, wb: 4'b0000, exp_ready: 4'b0001, exp_wbv: 1'b0};
        vecs[11] = '{valid: 4'b0011, wb: 4'b0010, exp_ready: 4'b0010, exp_wbv: 1'b1};

        reset        = 1'b1;
        commit_valid = '0;
        commit_wb    = '0;
        commit_sop   = '0;
        commit_eop   = '0;
        commit_uuid  = '0;
        commit_wid   = '0;
        commit_tmask = '0;
        commit_pc    = '0;
        commit_rd    = '0;
        commit_data  = '0;
        exp_ret      = '0;
        exp_thr      = '0;
        last_rd      = '0;
        repeat (2) @(posedge clk);
        do_reset(4'b0000);

        // Single ALU result with known payload.
        @(negedge clk);
        commit_valid          = 4'b0001;
        commit_wb             = 4'b0001;
        commit_sop            = 4'b0001;
        commit_eop            = 4'b0001;
        commit_rd[NRB-1:0]    = 6'd5;
        commit_tmask[NT-1:0]  = 4'b1011;
        commit_data[XL-1:0]   = 32'hDEADBEEF;
        #1;
        chk("alu_ready", 64'(commit_ready), 64'b0001);
        @(posedge clk);
        #1;
        exp_ret = 4'd1;
        exp_thr = 4'd3;
        last_rd = 6'd5;
        chk("alu_wbv", 64'(wb_valid), 64'd1);
        chk("alu_rd", 64'(wb_rd), 64'd5);
        chk("alu_tmask", 64'(wb_tmask), 64'b1011);
        chk("alu_data", 64'(wb_data[XL-1:0]), 64'hDEADBEEF);
        chk("alu_eop", 64'(wb_eop), 64'd1);
        chk_ctrs("alu");

        // Round-robin table; pointer starts at 1 after the ALU fire.
        for (int i = 0; i < 12; i++)
            cyc(vecs[i].valid, vecs[i].wb, 4'b1111, 4'b1111, vecs[i].exp_ready,
                vecs[i].exp_wbv, i, $sformatf("vec%0d", i));

        // Multi-packet lock on unit 1 while unit 2 waits.
        do_reset(4'b0000);
        cyc(4'b0110, 4'b1111, 4'b0110, 4'b0100, 4'b0010, 1'b1, 20, "lk_sop");
        cyc(4'b0100, 4'b1111, 4'b0110, 4'b0100, 4'b0010, 1'b0, 20, "lk_idle1");
        cyc(4'b0100, 4'b1111, 4'b0110, 4'b0100, 4'b0010, 1'b0, 20, "lk_idle2");
        cyc(4'b0110, 4'b1111, 4'b0100, 4'b0110, 4'b0010, 1'b1, 20, "lk_eop");
        cyc(4'b0100, 4'b1111, 4'b0100, 4'b0100, 4'b0100, 1'b1, 20, "lk_next");

        // Retire without writeback from SFU.
        cyc(4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 1'b0, 21, "sfu_nowb");

        // Reset while unit 1 holds the lock.
        do_reset(4'b0000);
        cyc(4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b1, 22, "rl_lock");
        do_reset(4'b0011);
        cyc(4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0001, 1'b1, 22, "rl_after");

        // Counter wrap with full thread masks (tag 11 gives unit 0 tmask 4'b1111).
        do_reset(4'b0000);
        for (int i = 0; i < 16; i++) begin
            cyc(4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b1, 11, $sformatf("wrap%0d", i));
`ifdef VX_WB_THREAD_STATS_EN
            if (i == 2) chk("wrap_thr3", 64'(thread_count), 64'd12);
`endif
        end
        chk("wrap_retire_zero", 64'(retire_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vx_commit_wb_arbiter.md
Name: vx_commit_wb_arbiter

Overview:
Commit-side producer of the per-slot writeback stream consumed by the issue stage's scoreboard and operand register file. One instance serves one issue slot. Each instance arbitrates the result streams of NUM_UNITS execution units (ALU, LSU, FPU, SFU) onto a single registered writeback channel. The channel has valid only and no ready. The block also counts retired instructions for that slot.

Parameters:
NUM_UNITS, 4, number of execution-unit commit inputs; unit index 0 = ALU, 1 = LSU, 2 = FPU, 3 = SFU
NUM_THREADS, 4, lanes per warp
NW_BITS, 2, warp id width
NR_BITS, 6, register id width
XLEN, 32, data width per lane
UUID_WIDTH, 1, instruction uuid width (min 1)
CTR_BITS, 32, width of the retire counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
commit_valid  in  NUM_UNITS  per-unit result valid
commit_ready  out  NUM_UNITS  per-unit result accepted
commit_uuid  in  NUM_UNITS*UUID_WIDTH  per-unit uuid
commit_wid  in  NUM_UNITS*NW_BITS  per-unit warp id
commit_tmask  in  NUM_UNITS*NUM_THREADS  per-unit thread mask
commit_pc  in  NUM_UNITS*XLEN  per-unit PC
commit_wb  in  NUM_UNITS  per-unit "writes rd" flag
commit_rd  in  NUM_UNITS*NR_BITS  per-unit destination register
commit_data  in  NUM_UNITS*NUM_THREADS*XLEN  per-unit lane results
commit_sop  in  NUM_UNITS  first packet of a result
commit_eop  in  NUM_UNITS  last packet of a result
wb_valid  out  1  writeback valid
wb_uuid  out  UUID_WIDTH  writeback uuid
wb_wid  out  NW_BITS  writeback warp id
wb_tmask  out  NUM_THREADS  writeback thread mask
wb_pc  out  XLEN  writeback PC
wb_rd  out  NR_BITS  writeback destination register
wb_data  out  NUM_THREADS*XLEN  writeback lane data
wb_eop  out  1  writeback last packet
retire_count  out  CTR_BITS  count of retired instructions
thread_count  out  CTR_BITS  count of retired active threads (optional feature)

Behaviour:
- Reset: drive all of the following to 0: wb_valid, wb_* fields, retire_count, thread_count, rr_ptr, lock state. While reset is high, commit_ready is 0.
- Arbitration: round-robin. Search starts at rr_ptr and runs over the units with commit_valid set; the first one found is the winner.
  - commit_ready[k] = grant[k], combinational, in the same cycle.
  - The output register is always loadable, so an input never stalls except by losing arbitration.
  - At most one commit_ready bit is high per cycle.
- Fire of unit k = commit_valid[k] && commit_ready[k].
- Pointer update: on a fire of unit k with commit_eop=1, rr_ptr <= (k+1) mod NUM_UNITS.
- Lock: a fire with commit_sop=1 and commit_eop=0 locks the grant to unit k.
  - While locked, only unit k can be granted, even when it is not valid; the other units see ready=0.
  - The lock clears on the fire of unit k with eop=1.
  - A single-packet result (sop=1, eop=1) never locks.
- Output stage: registered, latency 1 cycle from fire.
  - wb_valid <= fire && commit_wb[k].
  - wb_* fields <= the fields of unit k.
  - With no fire, or a fire with wb=0, wb_valid <= 0 and the fields hold their previous values.
  - wb_valid is high for at most one cycle per accepted packet.
- Retire: on a fire with eop=1, retire_count increments by 1, whether wb is 0 or 1. Packets without eop do not count.
- Counters wrap modulo 2^CTR_BITS; there is no saturation.
- Simultaneous events: a locked-unit eop fire and a new request from another unit in the same cycle → the other unit can win no earlier than the next cycle.
- Reset mid-operation clears the lock and rr_ptr. The first grant after reset goes to the lowest valid index ≥ 0.
- A zero-mask packet (tmask=0) is accepted and forwarded like any other packet.

Optional Feature:
- VX_WB_THREAD_STATS_EN defined: on every fire with eop=1, thread_count += $countones(commit_tmask of the winner), zero-extended to CTR_BITS.
- Not defined: the thread_count port still exists and is tied to 0; no adder or popcount logic is built.

Test Plan:
- Only unit 0 valid, wb=1, rd=5, tmask=4'b1011, data lane0=32'hDEADBEEF, sop=eop=1 → commit_ready[0]=1 in the same cycle. Next cycle: wb_valid=1, wb_rd=5, wb_tmask=4'b1011, wb_data lane0=32'hDEADBEEF, wb_eop=1. Then retire_count=1.
- All 4 units hold a single-packet result from reset → grants go to 0, 1, 2, 3 on consecutive cycles. wb_valid stays high for 4 cycles, retire_count=4, and no two ready bits are ever high together.
- Unit 1 sends sop=1/eop=0, then idles 2 cycles, then sends eop=1, with unit 2 valid throughout → commit_ready[2]=0 until unit 1's eop fires. The cycle after that, unit 2 is granted.
- Unit 3 result with wb=0, eop=1 → accepted; wb_valid stays 0; retire_count increments by 1.
- Reset asserted for 1 cycle while unit 1 holds the lock → after reset, units 0 and 1 both valid → unit 0 is granted first; retire_count=0.
- With CTR_BITS=4 and VX_WB_THREAD_STATS_EN defined: 16 retires with tmask=4'b1111 → retire_count wraps to 0; thread_count=64 mod 16 = 0. With 3 retires from reset, thread_count=12.
